// File: rtl/mult_error_monitor_pkg.sv
// Shared types and helpers for the approximate-multiplier error monitor.
// Holds the FSM state encoding, operand/product widths and the |x - y| helper.
package mult_eval_pkg;

  localparam int OPW = 8;
  localparam int PW  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A 17-bit signed difference keeps the full 0..65535 error range exact.
  function automatic logic [PW-1:0] abs_diff16(input logic [PW-1:0] x,
                                               input logic [PW-1:0] y);
    logic signed [PW:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    return d[PW] ? PW'(-d) : d[PW-1:0];
  endfunction

endpackage

// File: rtl/mult_error_monitor_if.sv
// Sample stream and result handshake between the multiplier harness and the monitor.
// master = harness side, slave = monitor side.
interface mult_error_monitor_if
  import mult_eval_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  parameter int SUM_W    = 16 + WIN_LOG2
) ();

  logic                in_valid;
  logic                in_ready;
  logic [OPW-1:0]      in_a;
  logic [OPW-1:0]      in_b;
  logic [PW-1:0]       in_p;

  logic                res_valid;
  logic                res_ready;
  logic [SUM_W-1:0]    res_sum_ed;
  logic [PW-1:0]       res_max_ed;
  logic [WIN_LOG2:0]   res_err_cnt;

  modport master (
    output in_valid, in_a, in_b, in_p, res_ready,
    input  in_ready, res_valid, res_sum_ed, res_max_ed, res_err_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, in_p, res_ready,
    output in_ready, res_valid, res_sum_ed, res_max_ed, res_err_cnt
  );

endinterface

// File: rtl/mult_error_monitor_ed_calc.sv
// Stage 1 of the monitor: registers the exact product and the approximate one,
// and exposes the error distance between them for the accumulating stage.
module ed_calc
  import mult_eval_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           load,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic [PW-1:0]  p,
  output logic           valid,
  output logic [PW-1:0]  ed
);

  logic [PW-1:0] prod_q;
  logic [PW-1:0] p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      prod_q <= '0;
      p_q    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        prod_q <= PW'(a) * PW'(b);
        p_q    <= p;
      end
    end
  end

  assign ed = abs_diff16(prod_q, p_q);

endmodule

// File: rtl/mult_error_monitor.sv
// Windowed error-metric monitor: accumulates sum, max and count of nonzero
// error distances over 2^WIN_LOG2 samples and presents them on a result handshake.
module mult_error_monitor
  import mult_eval_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  parameter int SUM_W    = 16 + WIN_LOG2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  mult_error_monitor_if.slave bus
);

  localparam int            CW        = WIN_LOG2 + 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LIMIT = CNT_ONE << WIN_LOG2;

  if (WIN_LOG2 < 1 || WIN_LOG2 > 16) begin : g_bad_win
    $error("mult_error_monitor: WIN_LOG2 must be in 1..16");
  end
  if (SUM_W < 16 + WIN_LOG2) begin : g_bad_sum
    $error("mult_error_monitor: SUM_W must be at least 16+WIN_LOG2");
  end

  state_t           state;
  logic [CW-1:0]    count;
  logic             in_ready_q;
  logic             res_valid_q;
  logic             busy_q;
  logic [SUM_W-1:0] acc_sum;
  logic [PW-1:0]    acc_max;
  logic [CW-1:0]    acc_err;
  logic [SUM_W-1:0] res_sum;
  logic [PW-1:0]    res_max;
  logic [CW-1:0]    res_err;
  logic             hs;
  logic             open_win;
  logic             s1_valid;
  logic [PW-1:0]    ed;

  assign hs       = bus.in_valid & in_ready_q;
  assign open_win = (state == IDLE) & start;

  ed_calc u_ed_calc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (open_win),
    .load  (hs),
    .a     (bus.in_a),
    .b     (bus.in_b),
    .p     (bus.in_p),
    .valid (s1_valid),
    .ed    (ed)
  );

  // RUN leaves only once the window is full and stage 1 has handed its last sample on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            count      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (hs) begin
            count      <= count + CNT_ONE;
            in_ready_q <= (count + CNT_ONE) != CNT_LIMIT;
          end
          if (count == CNT_LIMIT && !s1_valid) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state       <= DONE;
          res_valid_q <= 1'b1;
        end
        DONE: begin
          if (res_valid_q && bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result registers are separate so partial sums never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum <= '0;
      acc_max <= '0;
      acc_err <= '0;
      res_sum <= '0;
      res_max <= '0;
      res_err <= '0;
    end else begin
      if (open_win) begin
        acc_sum <= '0;
        acc_max <= '0;
        acc_err <= '0;
      end else if (s1_valid) begin
        acc_sum <= acc_sum + SUM_W'(ed);
        acc_err <= acc_err + CW'(ed != '0);
        if (ed > acc_max) begin
          acc_max <= ed;
        end
      end
      if (state == DRAIN) begin
        res_sum <= acc_sum;
        res_max <= acc_max;
        res_err <= acc_err;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_sum_ed  = res_sum;
  assign bus.res_max_ed  = res_max;
  assign bus.res_err_cnt = res_err;
  assign busy            = busy_q;

endmodule

// File: tb/tb_mult_error_monitor.sv
// Self-checking bench: directed and random windows on a 4-sample monitor, plus a
// random 256-sample window on the default configuration, against a behavioural model.
module tb_mult_error_monitor;

  logic clk;
  logic rst_n;
  logic sstart;
  logic sbusy;
  logic lstart;
  logic lbusy;

  int compared;
  int mismatched;

  logic [7:0]  sa [4];
  logic [7:0]  sb [4];
  logic [15:0] sp [4];

  mult_error_monitor_if #(.WIN_LOG2(2), .SUM_W(18)) sif ();
  mult_error_monitor_if #(.WIN_LOG2(8), .SUM_W(24)) lif ();

  mult_error_monitor #(.WIN_LOG2(2), .SUM_W(18)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .start (sstart),
    .busy  (sbusy),
    .bus   (sif)
  );

  mult_error_monitor dut_large (
    .clk   (clk),
    .rst_n (rst_n),
    .start (lstart),
    .busy  (lbusy),
    .bus   (lif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int edOf(input int a, input int b, input int p);
    int d;
    d = a * b - p;
    return (d < 0) ? -d : d;
  endfunction

  task automatic modelSmall(output int s, output int m, output int e);
    int d;
    s = 0; m = 0; e = 0;
    for (int i = 0; i < 4; i++) begin
      d = edOf(int'(sa[i]), int'(sb[i]), int'(sp[i]));
      s += d;
      if (d > m) m = d;
      if (d != 0) e++;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One full window on the small monitor, from start pulse to result handshake.
  task automatic applyStimulus(input string name, input int exp_sum, input int exp_max,
                               input int exp_err, input int bubbles, input int hold,
                               input int mid_start, input int offer_extra);
    int lat;
    sstart = 1'b1;
    nextCycle();
    sstart = 1'b0;
    checkOutput({name, ".busy"}, 32'(sbusy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      while (bubbles != 0 && $urandom_range(0, 2) == 0) begin
        sif.in_valid = 1'b0;
        nextCycle();
      end
      sif.in_valid = 1'b1;
      sif.in_a = sa[i];
      sif.in_b = sb[i];
      sif.in_p = sp[i];
      if (mid_start != 0 && i == 2) sstart = 1'b1;
      checkOutput({name, ".in_ready"}, 32'(sif.in_ready), 32'd1);
      nextCycle();
      sstart = 1'b0;
    end
    if (offer_extra != 0) begin
      sif.in_a = 8'd255;
      sif.in_b = 8'd255;
      sif.in_p = 16'd0;
    end else begin
      sif.in_valid = 1'b0;
    end
    checkOutput({name, ".ready_after_last"}, 32'(sif.in_ready), 32'd0);
    lat = 0;
    while (!sif.res_valid && lat < 20) begin
      nextCycle();
      lat++;
    end
    checkOutput({name, ".latency"}, 32'(lat), 32'd3);
    if (offer_extra != 0) begin
      checkOutput({name, ".ready_in_done"}, 32'(sif.in_ready), 32'd0);
    end
    sif.in_valid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      checkOutput({name, ".res_valid"}, 32'(sif.res_valid), 32'd1);
      checkOutput({name, ".sum"}, 32'(sif.res_sum_ed), 32'(exp_sum));
      checkOutput({name, ".max"}, 32'(sif.res_max_ed), 32'(exp_max));
      checkOutput({name, ".err"}, 32'(sif.res_err_cnt), 32'(exp_err));
      if (h < hold) nextCycle();
    end
    sif.res_ready = 1'b1;
    nextCycle();
    sif.res_ready = 1'b0;
    checkOutput({name, ".valid_cleared"}, 32'(sif.res_valid), 32'd0);
    checkOutput({name, ".idle"}, 32'(sbusy), 32'd0);
  endtask

  initial begin
    int es, em, ee, n, guard, lat, d, mode;
    int lsum, lmax, lerr;
    logic hs;
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0;
    sstart = 1'b0;
    lstart = 1'b0;
    sif.in_valid = 1'b0; sif.in_a = '0; sif.in_b = '0; sif.in_p = '0; sif.res_ready = 1'b0;
    lif.in_valid = 1'b0; lif.in_a = '0; lif.in_b = '0; lif.in_p = '0; lif.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    checkOutput("reset.busy", 32'(sbusy), 32'd0);
    checkOutput("reset.in_ready", 32'(sif.in_ready), 32'd0);
    checkOutput("reset.res_valid", 32'(sif.res_valid), 32'd0);
    checkOutput("reset.sum", 32'(sif.res_sum_ed), 32'd0);
    checkOutput("reset.max", 32'(sif.res_max_ed), 32'd0);
    checkOutput("reset.err", 32'(sif.res_err_cnt), 32'd0);

    sa = '{8'd3, 8'd255, 8'd0, 8'd128};
    sb = '{8'd5, 8'd255, 8'd7, 8'd2};
    sp = '{16'd15, 16'd65025, 16'd0, 16'd256};
    applyStimulus("exact", 0, 0, 0, 0, 0, 0, 0);

    sa = '{8'd200, 8'd10, 8'd4, 8'd9};
    sb = '{8'd200, 8'd10, 8'd4, 8'd9};
    sp = '{16'd39936, 16'd104, 16'd16, 16'd81};
    applyStimulus("mix", 68, 64, 2, 0, 0, 0, 0);

    sa = '{8'd255, 8'd0, 8'd0, 8'd0};
    sb = '{8'd255, 8'd0, 8'd0, 8'd0};
    sp = '{16'd0, 16'd65535, 16'd65535, 16'd65535};
    applyStimulus("extreme", 261630, 65535, 4, 0, 0, 0, 0);

    sa = '{8'd12, 8'd7, 8'd100, 8'd33};
    sb = '{8'd12, 8'd9, 8'd3, 8'd2};
    sp = '{16'd150, 16'd63, 16'd290, 16'd66};
    applyStimulus("backpressure", 16, 10, 2, 1, 5, 0, 1);

    sa = '{8'd1, 8'd2, 8'd3, 8'd4};
    sb = '{8'd1, 8'd2, 8'd3, 8'd4};
    sp = '{16'd2, 16'd4, 16'd12, 16'd16};
    applyStimulus("start_in_run", 4, 3, 2, 0, 0, 1, 0);

    sstart = 1'b1;
    nextCycle();
    sstart = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sif.in_valid = 1'b1;
      sif.in_a = 8'd50;
      sif.in_b = 8'd50;
      sif.in_p = 16'd0;
      nextCycle();
    end
    sif.in_valid = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    checkOutput("abort.busy", 32'(sbusy), 32'd0);
    checkOutput("abort.in_ready", 32'(sif.in_ready), 32'd0);
    checkOutput("abort.res_valid", 32'(sif.res_valid), 32'd0);
    checkOutput("abort.sum", 32'(sif.res_sum_ed), 32'd0);
    checkOutput("abort.max", 32'(sif.res_max_ed), 32'd0);
    checkOutput("abort.err", 32'(sif.res_err_cnt), 32'd0);
    nextCycle();

    sa = '{8'd20, 8'd5, 8'd6, 8'd7};
    sb = '{8'd20, 8'd5, 8'd6, 8'd7};
    sp = '{16'd401, 16'd25, 16'd36, 16'd49};
    applyStimulus("after_abort", 1, 1, 1, 0, 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        sa[i] = 8'($urandom);
        sb[i] = 8'($urandom);
        sp[i] = ($urandom_range(0, 1) == 0) ? 16'(sa[i] * sb[i]) : 16'($urandom);
      end
      modelSmall(es, em, ee);
      applyStimulus("rand_small", es, em, ee, 1, $urandom_range(0, 2), 0, 0);
    end

    lstart = 1'b1;
    nextCycle();
    lstart = 1'b0;
    lsum = 0; lmax = 0; lerr = 0; n = 0; guard = 0;
    while (n < 256 && guard < 5000) begin
      lif.in_valid = ($urandom_range(0, 3) != 0);
      lif.in_a = 8'($urandom);
      lif.in_b = 8'($urandom);
      mode = $urandom_range(0, 3);
      if (mode < 2) lif.in_p = 16'(lif.in_a * lif.in_b);
      else if (mode == 2) lif.in_p = 16'(lif.in_a * lif.in_b) ^ (16'd1 << $urandom_range(0, 15));
      else lif.in_p = 16'($urandom);
      hs = lif.in_valid & lif.in_ready;
      if (hs) begin
        d = edOf(int'(lif.in_a), int'(lif.in_b), int'(lif.in_p));
        lsum += d;
        if (d > lmax) lmax = d;
        if (d != 0) lerr++;
        n++;
      end
      nextCycle();
      guard++;
    end
    lif.in_valid = 1'b0;
    checkOutput("large.accepted", 32'(n), 32'd256);
    checkOutput("large.ready_after_last", 32'(lif.in_ready), 32'd0);
    lat = 0;
    while (!lif.res_valid && lat < 20) begin
      nextCycle();
      lat++;
    end
    checkOutput("large.latency", 32'(lat), 32'd3);
    checkOutput("large.sum", 32'(lif.res_sum_ed), 32'(lsum));
    checkOutput("large.max", 32'(lif.res_max_ed), 32'(lmax));
    checkOutput("large.err", 32'(lif.res_err_cnt), 32'(lerr));
    checkOutput("large.err_bound", 32'(lif.res_err_cnt <= 9'd256), 32'd1);
    lif.res_ready = 1'b1;
    nextCycle();
    lif.res_ready = 1'b0;
    checkOutput("large.valid_cleared", 32'(lif.res_valid), 32'd0);
    checkOutput("large.idle", 32'(lbusy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mult_error_monitor.md
Name: mult_error_monitor

Overview:
- Streaming error-metric stage that sits directly downstream of the approximate 8-bit multipliers (multiplier8bit_*).
- Each sample carries the operands A, B and the approximate product P from the multiplier under test. The block computes the exact product internally and forms the error distance ED = |A*B - P|.
- Over a window of 2^WIN_LOG2 samples it accumulates the sum of ED, the maximum ED and the count of erroneous samples, then presents them on a result handshake.
- Used by the NSGA-II evaluation harness to score candidate multipliers in hardware.

Parameters:
- WIN_LOG2, default 8: the window holds 2^WIN_LOG2 samples. Legal range is 1..16.
- SUM_W, default 16+WIN_LOG2: width of the ED sum. It must be at least 16+WIN_LOG2; this is checked by an elaboration assertion.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that opens a new window; acted on only in IDLE
- in_valid  in  1  sample valid
- in_ready  out  1  sample ready
- in_a  in  8  operand A
- in_b  in  8  operand B
- in_p  in  16  approximate product from the multiplier under test
- res_valid  out  1  result valid
- res_ready  in  1  result accepted by the consumer
- res_sum_ed  out  SUM_W  sum of ED over the window
- res_max_ed  out  16  maximum ED over the window
- res_err_cnt  out  WIN_LOG2+1  number of samples with ED != 0
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, active-low): every output and internal register goes to 0, and state goes to IDLE. Asserting rst_n low mid-window aborts the window; partial results are discarded and never presented.
- States:
  - IDLE: start=1 clears the accumulators, the sample counter and the stage-1 valid flag, then moves to RUN.
  - RUN: in_ready = 1 while the accepted-sample count is below 2^WIN_LOG2. Once the count reaches 2^WIN_LOG2, move to DRAIN; in_ready falls in the same cycle the count reaches the limit, so no extra sample is accepted.
  - DRAIN: in_ready = 0. Wait one cycle for stage 2 to absorb the final sample, then move to DONE.
  - DONE: res_valid = 1 and the result outputs are held stable. res_valid & res_ready moves to IDLE, clearing res_valid on the next edge.
- A start pulse in RUN, DRAIN or DONE is ignored.
- Handshake: a sample transfers on an edge where in_valid & in_ready. in_valid may toggle freely; gaps are allowed and do not advance the counter.
- Pipeline:
  - Stage 1 registers the exact 16-bit product in_a*in_b, in_p, and a valid flag.
  - Stage 2 computes a 17-bit signed difference, takes its absolute value to give a 16-bit ED, and updates sum += ED, max = max(max, ED) and err_cnt += (ED != 0).
  - Latency: res_valid rises 3 edges after the handshake edge of the final sample.
- Arithmetic: all unsigned. The sum cannot overflow given the SUM_W constraint, so no saturation logic is needed. ED of 65535 is representable.
- Window of length 1 (WIN_LOG2 = 1 means 2 samples): behaviour is the same, with no special case.
- A back-to-back window needs a fresh start pulse after DONE; a start on the same edge as the res_ready handshake is ignored.

Decomposition:
- Shared package mult_eval_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - constants OPW = 8 and PW = 16
  - a function abs_diff16
- Natural sub-module: ed_calc, the stage-1 registered exact multiply plus the absolute-difference logic. The FSM and accumulators stay in the top level.

Test Plan:
- Exact multiplier stream: with WIN_LOG2 = 2, send 4 samples where P = A*B (3*5=15, 255*255=65025, 0*7=0, 128*2=256). Required: sum = 0, max = 0, err_cnt = 0, with res_valid 3 cycles after the 4th handshake.
- Error mix: send A=200, B=200, P=39936 (ED 64); A=10, B=10, P=104 (ED 4); two exact samples. Required: sum = 68, max = 64, err_cnt = 2.
- Extreme ED: send A=255, B=255, P=0, then three samples with P=65535 and A=B=0 (ED 65535 each). Required: sum = 261630, max = 65535, err_cnt = 4, with no overflow.
- Backpressure and bubbles: drop in_valid randomly and hold res_ready low for 5 cycles in DONE. Required: results stable, res_valid held, in_ready = 0 after the 4th sample, and a 5th sample offered in DRAIN is not consumed.
- Control hazards: a start pulse in RUN does not reset the counts; rst_n pulsed low after 2 samples forces IDLE with all outputs 0, and a new start gives a clean window.
- Default WIN_LOG2 = 8 with random A, B and a random error model: compare against a scoreboard. res_err_cnt must be at most 256 and the sum must match exactly.
